// File: rtl/rx_pattern_classifier_if.sv
// Inbound beat stream, rule-table write port and tagged outbound stream
// of the RX pattern classifier.
interface rx_pattern_classifier_if #(
    parameter int DATA_W    = 64,
    parameter int NUM_RULES = 8
);
    localparam int BYTES = DATA_W / 8;
    localparam int LEN_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int IDX_W = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1;

    logic                 valid;
    logic                 sop;
    logic                 eop;
    logic [LEN_W-1:0]     length;
    logic [DATA_W-1:0]    data;
    logic                 rule_we;
    logic [IDX_W-1:0]     rule_idx;
    logic                 rule_en;
    logic [31:0]          rule_type;
    logic [63:0]          rule_sym;
    logic                 out_valid;
    logic                 out_sop;
    logic                 out_eop;
    logic [LEN_W-1:0]     out_length;
    logic [DATA_W-1:0]    out_data;
    logic [NUM_RULES-1:0] out_buffer;
    logic                 out_hit;
    logic                 out_miss;
    logic                 out_short;
    logic [15:0]          stat_pkts;
    logic [15:0]          stat_miss;
    logic [15:0]          stat_err;

    modport master (
        output valid, sop, eop, length, data,
        output rule_we, rule_idx, rule_en, rule_type, rule_sym,
        input  out_valid, out_sop, out_eop, out_length, out_data,
        input  out_buffer, out_hit, out_miss, out_short,
        input  stat_pkts, stat_miss, stat_err
    );

    modport slave (
        input  valid, sop, eop, length, data,
        input  rule_we, rule_idx, rule_en, rule_type, rule_sym,
        output out_valid, out_sop, out_eop, out_length, out_data,
        output out_buffer, out_hit, out_miss, out_short,
        output stat_pkts, stat_miss, stat_err
    );
endinterface

// File: rtl/rx_pattern_classifier.sv
// Extracts a 4-byte type and 8-byte symbol field from each RX packet, matches them
// against a writable rule table and tags the forwarded EOP beat with the result.
module rx_pattern_classifier #(
    parameter int DATA_W    = 64,
    parameter int NUM_RULES = 8,
    parameter int TYPE_OFF  = 14,
    parameter int SYM_OFF   = 24,
    parameter int BEAT_W    = 8
) (
    input logic                    clk_net,
    input logic                    rst,
    rx_pattern_classifier_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int LEN_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t            state;
    logic [BEAT_W-1:0] beat_cnt;
    logic [7:0]        type_q [4];
    logic [3:0]        type_msk;
    logic [7:0]        sym_q [8];
    logic [7:0]        sym_msk;

    logic              rule_en_q   [NUM_RULES];
    logic [31:0]       rule_type_q [NUM_RULES];
    logic [63:0]       rule_sym_q  [NUM_RULES];

    logic                 pkt_beat;
    logic [BEAT_W-1:0]    cur_beat;
    logic [7:0]           type_nx [4];
    logic [3:0]           type_msk_nx;
    logic [7:0]           sym_nx [8];
    logic [7:0]           sym_msk_nx;
    logic [31:0]          type_val;
    logic [63:0]          sym_val;
    logic                 fields_ok;
    logic [NUM_RULES-1:0] match;
    logic [NUM_RULES-1:0] buf_sel;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic lane_present(input int lane, input logic eop,
                                          input logic [LEN_W-1:0] len);
        return !eop || (LEN_W'(lane) <= len);
    endfunction

    // Merge captured field bytes with whatever the current beat contributes,
    // so the EOP decision sees bytes arriving on the EOP beat itself.
    always_comb begin
        pkt_beat    = bus.valid && (bus.sop || state == IN_PKT);
        cur_beat    = bus.sop ? '0 : beat_cnt;
        type_val    = '0;
        sym_val     = '0;
        type_msk_nx = '0;
        sym_msk_nx  = '0;
        for (int j = 0; j < 4; j++) begin
            if (cur_beat == BEAT_W'((TYPE_OFF + j) / BYTES) &&
                lane_present((TYPE_OFF + j) % BYTES, bus.eop, bus.length)) begin
                type_nx[j]     = bus.data[8*((TYPE_OFF + j) % BYTES) +: 8];
                type_msk_nx[j] = 1'b1;
            end else begin
                type_nx[j]     = type_q[j];
                type_msk_nx[j] = !bus.sop && type_msk[j];
            end
            type_val[31-8*j -: 8] = type_nx[j];
        end
        for (int j = 0; j < 8; j++) begin
            if (cur_beat == BEAT_W'((SYM_OFF + j) / BYTES) &&
                lane_present((SYM_OFF + j) % BYTES, bus.eop, bus.length)) begin
                sym_nx[j]     = bus.data[8*((SYM_OFF + j) % BYTES) +: 8];
                sym_msk_nx[j] = 1'b1;
            end else begin
                sym_nx[j]     = sym_q[j];
                sym_msk_nx[j] = !bus.sop && sym_msk[j];
            end
            sym_val[63-8*j -: 8] = sym_nx[j];
        end
        fields_ok = (&type_msk_nx) && (&sym_msk_nx);
        for (int i = 0; i < NUM_RULES; i++) begin
            match[i] = rule_en_q[i] && (rule_type_q[i] == type_val) &&
                       (rule_sym_q[i] == sym_val);
        end
        buf_sel = match & (~match + NUM_RULES'(1));
    end

    // Output stage: every out_* register is loaded from the beat one cycle earlier.
    always_ff @(posedge clk_net or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            beat_cnt       <= '0;
            type_msk       <= '0;
            sym_msk        <= '0;
            type_q         <= '{default: '0};
            sym_q          <= '{default: '0};
            rule_en_q      <= '{default: 1'b0};
            rule_type_q    <= '{default: '0};
            rule_sym_q     <= '{default: '0};
            bus.out_valid  <= 1'b0;
            bus.out_sop    <= 1'b0;
            bus.out_eop    <= 1'b0;
            bus.out_length <= '0;
            bus.out_data   <= '0;
            bus.out_buffer <= '0;
            bus.out_hit    <= 1'b0;
            bus.out_miss   <= 1'b0;
            bus.out_short  <= 1'b0;
            bus.stat_pkts  <= '0;
            bus.stat_miss  <= '0;
            bus.stat_err   <= '0;
        end else begin
            bus.out_valid  <= bus.valid;
            bus.out_sop    <= bus.valid && bus.sop;
            bus.out_eop    <= bus.valid && bus.eop;
            bus.out_length <= bus.length;
            bus.out_data   <= bus.data;
            bus.out_buffer <= '0;
            bus.out_hit    <= 1'b0;
            bus.out_miss   <= 1'b0;
            bus.out_short  <= 1'b0;

            if (bus.rule_we && (int'(bus.rule_idx) < NUM_RULES)) begin
                rule_en_q[bus.rule_idx]   <= bus.rule_en;
                rule_type_q[bus.rule_idx] <= bus.rule_type;
                rule_sym_q[bus.rule_idx]  <= bus.rule_sym;
            end

            if (pkt_beat) begin
                type_q   <= type_nx;
                sym_q    <= sym_nx;
                type_msk <= type_msk_nx;
                sym_msk  <= sym_msk_nx;
                beat_cnt <= (cur_beat == BEAT_MAX) ? cur_beat : cur_beat + BEAT_W'(1);
                if (bus.sop && state == IN_PKT) begin
                    bus.stat_err <= sat_inc16(bus.stat_err);
                end
                if (bus.eop) begin
                    state          <= IDLE;
                    bus.out_short  <= !fields_ok;
                    bus.out_hit    <= fields_ok && (|match);
                    bus.out_miss   <= !(fields_ok && (|match));
                    bus.out_buffer <= fields_ok ? buf_sel : '0;
                    bus.stat_pkts  <= sat_inc16(bus.stat_pkts);
                    if (!(fields_ok && (|match))) begin
                        bus.stat_miss <= sat_inc16(bus.stat_miss);
                    end
                end else begin
                    state <= IN_PKT;
                end
            end else if (bus.valid) begin
                bus.stat_err <= sat_inc16(bus.stat_err);
            end
        end
    end
endmodule

// File: tb/tb_rx_pattern_classifier.sv
// Directed and randomized bench for rx_pattern_classifier against a byte-queue
// reference model of packets, rules and statistics.
module tb_rx_pattern_classifier;
    localparam int DATA_W    = 64;
    localparam int NUM_RULES = 8;
    localparam int TYPE_OFF  = 14;
    localparam int SYM_OFF   = 24;
    localparam int BEAT_W    = 8;

    logic clk_net = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_net = ~clk_net;

    rx_pattern_classifier_if #(.DATA_W(DATA_W), .NUM_RULES(NUM_RULES)) bus ();

    rx_pattern_classifier #(
        .DATA_W(DATA_W), .NUM_RULES(NUM_RULES), .TYPE_OFF(TYPE_OFF),
        .SYM_OFF(SYM_OFF), .BEAT_W(BEAT_W)
    ) dut (
        .clk_net(clk_net),
        .rst    (rst),
        .bus    (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic        m_en   [NUM_RULES];
    logic [31:0] m_type [NUM_RULES];
    logic [63:0] m_sym  [NUM_RULES];
    int          m_pkts, m_miss, m_err;
    bit          m_open;
    logic [7:0]  pkt [$];

    logic                 exp_valid, exp_sop, exp_eop, exp_hit, exp_miss, exp_short;
    logic [2:0]           exp_len;
    logic [63:0]          exp_data;
    logic [NUM_RULES-1:0] exp_buf;

    logic [31:0] pool_type [4];
    logic [63:0] pool_sym  [4];
    logic [63:0] std_beats [4];

    function automatic int sat(input int x);
        return (x == 65535) ? x : x + 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_RULES; i++) begin
            m_en[i] = 1'b0; m_type[i] = '0; m_sym[i] = '0;
        end
        m_pkts = 0; m_miss = 0; m_err = 0; m_open = 0;
        pkt.delete();
    endtask

    task automatic model_beat(input logic v, input logic s, input logic e,
                              input logic [2:0] len, input logic [63:0] d);
        logic [31:0] ty;
        logic [63:0] sy;
        int n;
        exp_valid = v; exp_sop = v && s; exp_eop = v && e;
        exp_len = len; exp_data = d;
        exp_buf = '0; exp_hit = 0; exp_miss = 0; exp_short = 0;
        if (!v) return;
        if (s) begin
            if (m_open) m_err = sat(m_err);
            pkt.delete();
            m_open = 1;
        end
        if (!m_open) begin
            m_err = sat(m_err);
            return;
        end
        n = e ? int'(len) + 1 : 8;
        for (int k = 0; k < n; k++) pkt.push_back(d[8*k +: 8]);
        if (!e) return;
        m_open = 0;
        m_pkts = sat(m_pkts);
        if (pkt.size() < TYPE_OFF + 4 || pkt.size() < SYM_OFF + 8) begin
            exp_short = 1; exp_miss = 1;
        end else begin
            ty = '0; sy = '0;
            for (int j = 0; j < 4; j++) ty = {ty[23:0], pkt[TYPE_OFF + j]};
            for (int j = 0; j < 8; j++) sy = {sy[55:0], pkt[SYM_OFF + j]};
            for (int i = 0; i < NUM_RULES; i++) begin
                if (!exp_hit && m_en[i] && m_type[i] == ty && m_sym[i] == sy) begin
                    exp_hit = 1; exp_buf[i] = 1'b1;
                end
            end
            exp_miss = !exp_hit;
        end
        if (exp_miss) m_miss = sat(m_miss);
    endtask

    task automatic check_outputs();
        chk("out_valid", 64'(bus.out_valid), 64'(exp_valid));
        chk("out_sop", 64'(bus.out_sop), 64'(exp_sop));
        chk("out_eop", 64'(bus.out_eop), 64'(exp_eop));
        if (exp_valid) begin
            chk("out_data", bus.out_data, exp_data);
            chk("out_length", 64'(bus.out_length), 64'(exp_len));
        end
        chk("out_buffer", 64'(bus.out_buffer), 64'(exp_buf));
        chk("out_hit", 64'(bus.out_hit), 64'(exp_hit));
        chk("out_miss", 64'(bus.out_miss), 64'(exp_miss));
        chk("out_short", 64'(bus.out_short), 64'(exp_short));
        chk("stat_pkts", 64'(bus.stat_pkts), 64'(m_pkts));
        chk("stat_miss", 64'(bus.stat_miss), 64'(m_miss));
        chk("stat_err", 64'(bus.stat_err), 64'(m_err));
    endtask

    task automatic cycle(input logic v, input logic s, input logic e,
                         input logic [2:0] len, input logic [63:0] d,
                         input logic we, input logic [2:0] idx, input logic en,
                         input logic [31:0] ty, input logic [63:0] sy);
        @(negedge clk_net);
        bus.valid = v; bus.sop = s; bus.eop = e; bus.length = len; bus.data = d;
        bus.rule_we = we; bus.rule_idx = idx; bus.rule_en = en;
        bus.rule_type = ty; bus.rule_sym = sy;
        model_beat(v, s, e, len, d);
        @(posedge clk_net);
        #1;
        if (we) begin
            m_en[idx] = en; m_type[idx] = ty; m_sym[idx] = sy;
        end
        check_outputs();
    endtask

    task automatic beat(input logic v, input logic s, input logic e,
                        input logic [2:0] len, input logic [63:0] d);
        cycle(v, s, e, len, d, 1'b0, 3'd0, 1'b0, 32'd0, 64'd0);
    endtask

    task automatic write_rule(input logic [2:0] idx, input logic en,
                              input logic [31:0] ty, input logic [63:0] sy);
        cycle(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 1'b1, idx, en, ty, sy);
    endtask

    task automatic send_std(input logic [2:0] last_len, input bit gaps);
        for (int b = 0; b < 4; b++) begin
            if (gaps && b > 0) beat(1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
            beat(1'b1, b == 0, b == 3, (b == 3) ? last_len : 3'd0, std_beats[b]);
        end
    endtask

    task automatic send_random_packet();
        logic [7:0]  pb [$];
        logic [63:0] d;
        int nb, last, nbytes, r;
        bit wr;
        nb     = $urandom_range(1, 6);
        last   = $urandom_range(0, 7);
        nbytes = (nb - 1) * 8 + last + 1;
        for (int k = 0; k < nbytes; k++) pb.push_back(8'($urandom));
        if ($urandom_range(0, 3) != 0) begin
            r = $urandom_range(0, 3);
            for (int j = 0; j < 4; j++)
                if (TYPE_OFF + j < nbytes) pb[TYPE_OFF + j] = pool_type[r][31-8*j -: 8];
            for (int j = 0; j < 8; j++)
                if (SYM_OFF + j < nbytes) pb[SYM_OFF + j] = pool_sym[r][63-8*j -: 8];
        end
        if ($urandom_range(0, 9) == 0) beat(1'b1, 1'b0, 1'b0, 3'd0, 64'($urandom));
        for (int b = 0; b < nb; b++) begin
            if ($urandom_range(0, 3) == 0) beat(1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
            d = {$urandom, $urandom};
            for (int k = 0; k < 8; k++)
                if (b * 8 + k < nbytes) d[8*k +: 8] = pb[b * 8 + k];
            wr = ($urandom_range(0, 9) == 0);
            r  = $urandom_range(0, 3);
            cycle(1'b1, b == 0, b == nb - 1, (b == nb - 1) ? 3'(last) : 3'd0, d,
                  wr, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  pool_type[r], pool_sym[r]);
        end
    endtask

    initial begin
        std_beats[0] = 64'h0;
        std_beats[1] = 64'hBBAA000000000000;
        std_beats[2] = 64'h000000000000DDCC;
        std_beats[3] = 64'hEFBEADDEEFBEADDE;
        bus.valid = 0; bus.sop = 0; bus.eop = 0; bus.length = 0; bus.data = 0;
        bus.rule_we = 0; bus.rule_idx = 0; bus.rule_en = 0;
        bus.rule_type = 0; bus.rule_sym = 0;
        model_reset();
        model_beat(1'b0, 1'b0, 1'b0, 3'd0, 64'd0);

        // Reset state
        repeat (2) @(negedge clk_net);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_stat_pkts", 64'(bus.stat_pkts), 64'd0);
        chk("rst_stat_err", 64'(bus.stat_err), 64'd0);
        rst = 1'b0;

        // Basic match on rule0
        write_rule(3'd0, 1'b1, 32'hAABBCCDD, 64'hDEADBEEFDEADBEEF);
        send_std(3'd7, 1'b0);
        chk("tp1_eop", 64'(bus.out_eop), 64'd1);
        chk("tp1_buffer", 64'(bus.out_buffer), 64'h01);
        chk("tp1_hit", 64'(bus.out_hit), 64'd1);
        chk("tp1_pkts", 64'(bus.stat_pkts), 64'd1);

        // Priority, then lower-priority rule after disabling rule0
        write_rule(3'd5, 1'b1, 32'hAABBCCDD, 64'hDEADBEEFDEADBEEF);
        send_std(3'd7, 1'b0);
        chk("tp2_prio", 64'(bus.out_buffer), 64'h01);
        write_rule(3'd0, 1'b0, 32'hAABBCCDD, 64'hDEADBEEFDEADBEEF);
        send_std(3'd7, 1'b0);
        chk("tp2_rule5", 64'(bus.out_buffer), 64'h20);

        // Short packet
        send_std(3'd3, 1'b0);
        chk("tp3_short", 64'(bus.out_short), 64'd1);
        chk("tp3_miss", 64'(bus.out_miss), 64'd1);
        chk("tp3_buffer", 64'(bus.out_buffer), 64'd0);
        chk("tp3_stat_miss", 64'(bus.stat_miss), 64'd1);

        // Abandoned packet followed by a full one
        write_rule(3'd0, 1'b1, 32'hAABBCCDD, 64'hDEADBEEFDEADBEEF);
        beat(1'b1, 1'b1, 1'b0, 3'd0, std_beats[0]);
        beat(1'b1, 1'b0, 1'b0, 3'd0, std_beats[1]);
        send_std(3'd7, 1'b0);
        chk("tp4_err", 64'(bus.stat_err), 64'd1);
        chk("tp4_one_tag", 64'(bus.stat_pkts), 64'd5);
        chk("tp4_buffer", 64'(bus.out_buffer), 64'h01);

        // Lone EOP in IDLE, then gapped packet
        beat(1'b1, 1'b0, 1'b1, 3'd7, 64'h0123456789ABCDEF);
        chk("tp5_lone_eop", 64'(bus.out_eop), 64'd1);
        chk("tp5_lone_untag", 64'({bus.out_buffer, bus.out_hit, bus.out_miss}), 64'd0);
        chk("tp5_lone_err", 64'(bus.stat_err), 64'd2);
        send_std(3'd7, 1'b1);
        chk("tp5_gap_buffer", 64'(bus.out_buffer), 64'h01);

        // Rule write coinciding with EOP uses the old table
        for (int b = 0; b < 3; b++) beat(1'b1, b == 0, 1'b0, 3'd0, std_beats[b]);
        cycle(1'b1, 1'b0, 1'b1, 3'd7, std_beats[3], 1'b1, 3'd0, 1'b0,
              32'hAABBCCDD, 64'hDEADBEEFDEADBEEF);
        chk("tp6_old_rule", 64'(bus.out_buffer), 64'h01);
        send_std(3'd7, 1'b0);
        chk("tp6_new_rule", 64'(bus.out_buffer), 64'h20);

        // Asynchronous reset during beat2
        beat(1'b1, 1'b1, 1'b0, 3'd0, std_beats[0]);
        beat(1'b1, 1'b0, 1'b0, 3'd0, std_beats[1]);
        @(negedge clk_net);
        bus.valid = 1; bus.sop = 0; bus.eop = 0; bus.data = std_beats[2];
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_out_data", bus.out_data, 64'd0);
        chk("arst_stat_pkts", 64'(bus.stat_pkts), 64'd0);
        chk("arst_stat_err", 64'(bus.stat_err), 64'd0);
        model_reset();
        @(negedge clk_net);
        rst = 1'b0; bus.valid = 0;
        send_std(3'd7, 1'b0);
        chk("tp7_cleared_rules", 64'(bus.out_miss), 64'd1);
        write_rule(3'd0, 1'b1, 32'hAABBCCDD, 64'hDEADBEEFDEADBEEF);
        send_std(3'd7, 1'b0);
        chk("tp7_reprogrammed", 64'(bus.out_buffer), 64'h01);

        // Randomized traffic and rule updates
        for (int i = 0; i < 4; i++) begin
            pool_type[i] = $urandom;
            pool_sym[i]  = {$urandom, $urandom};
        end
        for (int i = 0; i < NUM_RULES; i++)
            write_rule(3'(i), 1'($urandom_range(0, 3) != 0), pool_type[i % 4], pool_sym[i % 4]);
        for (int p = 0; p < 80; p++) send_random_packet();
        beat(1'b0, 1'b0, 1'b0, 3'd0, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/rx_pattern_classifier.md
# rx_pattern_classifier

Parametrised successor of the RX streaming pattern detector. Sits in the `clk_net` domain on the inbound packet stream, between the MAC-side beat interface and the per-buffer FIFOs. It extracts a 4-byte packet-type field and an 8-byte symbol field at configurable byte offsets, and compares them against a runtime-writable table of `NUM_RULES` rules. Each beat is forwarded one cycle later, and the EOP beat is tagged with a priority one-hot buffer select plus hit/miss/short status and statistics.

## Interface
- `DATA_W`, 64: beat width in bits, multiple of 64. `BYTES = DATA_W/8`.
- `NUM_RULES`, 8: rule table entries, 1..16.
- `TYPE_OFF`, 14: byte offset of the 4-byte type field from SOP byte 0.
- `SYM_OFF`, 24: byte offset of the 8-byte symbol field.
- `BEAT_W`, 8: beat counter width. Both fields must end below byte `BYTES*(2^BEAT_W - 1)`.
- `clk_net` in 1: single clock, 250 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `valid`, `sop`, `eop` in 1 each: beat qualifiers.
- `length` in clog2(BYTES): valid bytes minus 1 on the EOP beat. Ignored on other beats.
- `data` in DATA_W: beat data. Byte k of a beat is at `data[8k+7:8k]`.
- `rule_we` in 1: rule table write strobe.
- `rule_idx` in clog2(NUM_RULES): rule table write index.
- `rule_en` in 1: rule enable value to write.
- `rule_type` in 32: packet-type value to write.
- `rule_sym` in 64: symbol value to write.
- `out_valid`, `out_sop`, `out_eop` out 1 each: registered copies of the input qualifiers.
- `out_length` out clog2(BYTES): registered copy of `length`.
- `out_data` out DATA_W: registered copy of `data`.
- `out_buffer` out NUM_RULES: one-hot select of the lowest-index matching rule. Zero except on a hit EOP beat.
- `out_hit`, `out_miss`, `out_short` out 1 each: status flags, valid only on the EOP beat.
- `stat_pkts`, `stat_miss`, `stat_err` out 16 each: saturating counters.

## Operation
- Packet byte n sits in beat n/BYTES, lane n%BYTES.
- Fields are assembled big-endian. The type is `{b[TYPE_OFF], …, b[TYPE_OFF+3]}`; the symbol is assembled the same way from `SYM_OFF`.
- FSM states are IDLE and IN_PKT. Only beats with `valid=1` are considered; idle gaps inside a packet are allowed.
- IDLE:
  - `sop` moves the FSM to IN_PKT, sets the beat counter to 0, and clears the field-byte valid masks.
  - `sop` together with `eop` is a single-beat packet; it is processed and the FSM stays in IDLE.
  - A non-SOP beat is forwarded with no tag, increments `stat_err`, and is otherwise ignored.
- IN_PKT:
  - Each beat increments the beat counter, which saturates at 2^BEAT_W-1.
  - Field bytes whose position lies in the current beat are captured into the type/sym registers, and their mask bits are set.
  - On an EOP beat, only lanes 0..`length` count as present.
- SOP while in IN_PKT:
  - The open packet is abandoned and `stat_err` increments.
  - The new packet starts from this beat.
  - The abandoned packet produces no EOP tag.
- EOP decision is made combinationally from the captured bytes plus the current beat's bytes:
  - If any field byte is missing: `out_short=1`, `out_buffer=0`, `out_miss=1`.
  - Otherwise, rule i matches when `en[i]`, `type==rule_type[i]` and `sym==rule_sym[i]`. `out_buffer` is the lowest-index match; `out_hit=|matches`, `out_miss=~out_hit`.
- Statistics update on every EOP beat:
  - `stat_pkts` increments on every EOP beat.
  - `stat_miss` increments when `out_miss` is set.
  - All counters saturate at 16'hFFFF.
- Rule writes:
  - A write takes effect the next cycle.
  - The table is read at the EOP cycle, so a write landing mid-packet affects that packet.
  - Writes with `rule_idx ≥ NUM_RULES` are ignored.

## Timing
- All `out_*` signals are registered, with fixed 1-cycle latency from the input beat.
- There is no backpressure and the block accepts a beat every cycle.
- Reset values:
  - All outputs and counters are 0.
  - All rules have `en=0` and type/sym 0.
  - The FSM is in IDLE.
- Asserting reset mid-packet drops the packet and clears the output register that same cycle, asynchronously.
- A `valid=0` cycle produces `out_valid=0`. All tag and status outputs are 0 whenever `out_eop=0`.
- A `rule_we` write in the same cycle as an EOP beat is not visible to that beat; the old table value is used.

## Test plan
- Program rule0 with `en=1`, type AABBCCDD, sym DEADBEEFDEADBEEF. Send a 4-beat packet:
  - beat0 `sop`, data 0;
  - beat1 data 64'hBBAA000000000000;
  - beat2 data 64'h000000000000DDCC;
  - beat3 `eop`, `length=7`, data 64'hEFBEADDEEFBEADDE.
  - Required: one cycle after beat3, `out_eop=1`, `out_buffer=8'h01`, `out_hit=1`, `stat_pkts=1`.
- Program rule0 and rule5 identically, then send the same packet. Required: `out_buffer=8'h01` (priority). Then disable rule0 and resend. Required: `out_buffer=8'h20`.
- Send the same packet with beat3 `length=3`. Required: `out_short=1`, `out_miss=1`, `out_buffer=0`, `stat_miss=1`.
- Send SOP, beat1, then a new SOP and the full matching packet. Required: `stat_err=1`, exactly one EOP tag, `out_buffer=8'h01`.
- Send a lone `eop` beat in IDLE. Required: forwarded untagged, `stat_err` increments. Separately, insert `valid=0` gaps between every beat of the matching packet. Required: the result is unchanged.
- Assert `rst` during beat2. Required: outputs are 0 immediately. A subsequent clean packet matches only after the rules are reprogrammed.
